// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline.
// Holds one instruction between execute and writeback. Non-loads pass through
// in one cycle. A load waits for the data SRAM to return its data. If writeback
// is stalled when the data arrives, the data is parked in hold_r until
// writeback can take it.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } load_state_t;

  load_state_t                state;
  load_state_t                state_nxt;
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic [31:0]                hold_r;

  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        ms_ready_go;
  logic [31:0] final_result;
  logic [4:0]  fwd_dest;
  logic        accept;
  logic        load_accept;
  logic        nonload_accept;
  logic        capture_hold;

  assign res_from_mem = bus_r[70];
  assign gr_we        = bus_r[69];
  assign dest         = bus_r[68:64];
  assign alu_result   = bus_r[63:32];
  assign pc           = bus_r[31:0];

  assign accept         = es_to_ms_valid && ms_allowin;
  assign load_accept    = accept && es_to_ms_bus[70];
  assign nonload_accept = accept && !es_to_ms_bus[70];

  // Ready/result selection: a load is ready once its data is parked or arrives this cycle.
  always_comb begin
    ms_ready_go  = 1'b1;
    final_result = alu_result;
    if (res_from_mem) begin
      ms_ready_go  = (state == S_HOLD) || ((state == S_WAIT) && data_sram_data_ok);
      final_result = (state == S_HOLD) ? hold_r : data_sram_rdata;
    end else begin
      ms_ready_go  = 1'b1;
      final_result = alu_result;
    end
  end

  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // Only parks data when writeback stalls. Because ms_allowin is then low, no
  // new load can be accepted in the same cycle.
  assign capture_hold = (state == S_WAIT) && data_sram_data_ok && !ws_allowin;

  // Load-tracking next state: a new acceptance overrides whatever the old instruction was doing.
  always_comb begin
    state_nxt = state;
    if (load_accept) begin
      state_nxt = S_WAIT;
    end else if (nonload_accept) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_WAIT: begin
          if (data_sram_data_ok) begin
            state_nxt = ws_allowin ? S_IDLE : S_HOLD;
          end else begin
            state_nxt = S_WAIT;
          end
        end
        S_HOLD: begin
          if (ws_allowin) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_HOLD;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Load-tracking state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pipeline valid bit and the instruction payload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      bus_r    <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (accept) begin
        bus_r <= es_to_ms_bus;
      end
    end
  end

  // Parks returned load data while writeback is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_r <= 32'h0000_0000;
    end else if (capture_hold) begin
      hold_r <= data_sram_rdata;
    end
  end

  assign fwd_dest = (ms_valid && gr_we) ? dest : 5'b00000;

  assign ms_to_ws_bus = {gr_we && ms_valid, dest, final_result, pc};
  assign ms_to_ds_bus = {ms_valid && res_from_mem, ms_valid && ms_ready_go, fwd_dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// A transaction-level model tracks the resident instruction and whether its
// load data has arrived. Directed scenarios are followed by random traffic.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [70:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int checks = 0;
  int failures = 0;

  // Model: the resident instruction, and the load data if it has already arrived.
  logic        m_valid;
  logic [70:0] m_bus;
  logic        m_have;
  logic [31:0] m_data;

  logic [31:0] done_q[$];

  localparam logic [32:0] NW = 33'h0;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_to_ds_bus     (ms_to_ds_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [70:0] mk(input logic ld, input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {ld, we, d, alu, pc};
  endfunction

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge: drive inputs, check at the falling edge, then advance the model.
  task automatic cycle(input logic v, input logic [70:0] b, input logic ws, input logic dok,
                       input logic [31:0] rd, input logic [32:0] want);
    logic        is_load, dnow, ready, exp_allow, exp_wsv;
    logic [4:0]  exp_fwd;
    logic [31:0] exp_res;
    logic        nv, nh;
    logic [70:0] nb;
    logic [31:0] nd;
    es_to_ms_valid    = v;
    es_to_ms_bus      = b;
    ws_allowin        = ws;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    @(negedge clk);
    is_load   = m_valid && m_bus[70];
    dnow      = is_load && !m_have && dok;
    ready     = !is_load || m_have || dnow;
    exp_allow = !m_valid || (ready && ws);
    exp_wsv   = m_valid && ready;
    exp_fwd   = (m_valid && m_bus[69]) ? m_bus[68:64] : 5'd0;
    exp_res   = !is_load ? m_bus[63:32] : (m_have ? m_data : rd);
    chk("allowin", 71'(ms_allowin), 71'(exp_allow));
    chk("ws_valid", 71'(ms_to_ws_valid), 71'(exp_wsv));
    chk("ds_hdr", 71'(ms_to_ds_bus[38:32]), 71'({m_valid && m_bus[70], exp_wsv, exp_fwd}));
    if (exp_wsv) begin
      chk("ws_bus", 71'(ms_to_ws_bus), 71'({m_bus[69], m_bus[68:64], exp_res, m_bus[31:0]}));
      chk("ds_res", 71'(ms_to_ds_bus[31:0]), 71'(exp_res));
    end else if (!m_valid) begin
      chk("we_gate", 71'(ms_to_ws_bus[69]), 71'(1'b0));
    end
    if (want[32]) begin
      chk("want_res", 71'(ms_to_ws_bus[63:32]), 71'(want[31:0]));
    end
    if (ms_to_ws_valid && ws) begin
      done_q.push_back(ms_to_ws_bus[63:32]);
    end
    nv = m_valid; nb = m_bus; nh = m_have; nd = m_data;
    if (exp_allow) begin
      nv = v;
      nh = 1'b0;
      if (v) nb = b;
    end else if (dnow) begin
      nh = 1'b1;
      nd = rd;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_bus = nb; m_have = nh; m_data = nd;
  endtask

  // Entered just after a rising edge: pulse reset asynchronously and check the reset view.
  task automatic do_reset();
    resetn = 1'b0;
    #2;
    chk("rst_allowin", 71'(ms_allowin), 71'(1'b1));
    chk("rst_ws_valid", 71'(ms_to_ws_valid), 71'(1'b0));
    chk("rst_ds_bus", 71'(ms_to_ds_bus), 71'(39'h0));
    m_valid = 1'b0; m_bus = '0; m_have = 1'b0; m_data = 32'h0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    m_valid = 1'b0; m_bus = '0; m_have = 1'b0; m_data = 32'h0;
    @(posedge clk);
    #1;
    do_reset();

    // Non-load, one-cycle latency, forwards dest 5.
    cycle(1'b1, mk(1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h1000), 1'b1, 1'b0, 32'h0, NW);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, {1'b1, 32'h0000_1234});
    chk("nl_fwd_next", 71'(ms_to_ds_bus[36:32]), 71'(5'd0));

    // Load with data three cycles after acceptance.
    cycle(1'b1, mk(1'b1, 1'b1, 5'd3, 32'h0, 32'h1004), 1'b1, 1'b0, 32'h0, NW);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h1111_1111, NW);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h2222_2222, NW);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF, {1'b1, 32'hDEAD_BEEF});
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h3333_3333, NW);

    // Load whose data arrives while writeback stalls.
    cycle(1'b1, mk(1'b1, 1'b1, 5'd9, 32'h0, 32'h1008), 1'b1, 1'b0, 32'h0, NW);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'hCAFE_F00D, {1'b1, 32'hCAFE_F00D});
    cycle(1'b1, mk(1'b0, 1'b1, 5'd1, 32'h5, 32'h100C), 1'b0, 1'b1, 32'h0BAD_0BAD, {1'b1, 32'hCAFE_F00D});
    cycle(1'b1, mk(1'b0, 1'b1, 5'd1, 32'h5, 32'h100C), 1'b0, 1'b0, 32'h0BAD_0BAD, {1'b1, 32'hCAFE_F00D});
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h4444_4444, {1'b1, 32'hCAFE_F00D});
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, NW);

    // Back-to-back loads completing in order.
    done_q.delete();
    cycle(1'b1, mk(1'b1, 1'b1, 5'd10, 32'h0, 32'h2000), 1'b1, 1'b0, 32'h0, NW);
    cycle(1'b1, mk(1'b1, 1'b1, 5'd11, 32'h0, 32'h2004), 1'b1, 1'b1, 32'hAAAA_0001, NW);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'hBBBB_0002, NW);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, NW);
    chk("b2b_count", 71'(done_q.size()), 71'(2));
    if (done_q.size() == 2) begin
      chk("b2b_first", 71'(done_q[0]), 71'(32'hAAAA_0001));
      chk("b2b_second", 71'(done_q[1]), 71'(32'hBBBB_0002));
    end

    // Reset while a load is waiting; a late data_ok is ignored.
    cycle(1'b1, mk(1'b1, 1'b1, 5'd12, 32'h0, 32'h3000), 1'b1, 1'b0, 32'h0, NW);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, NW);
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h5555_5555, NW);

    // Stale bus content after the slot empties must not forward.
    cycle(1'b1, mk(1'b0, 1'b1, 5'd7, 32'h77, 32'h4000), 1'b1, 1'b0, 32'h0, NW);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, {1'b1, 32'h0000_0077});
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, NW);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)),
            mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom),
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            $urandom, NW);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
